full_adder_1b: RTL and testbench

- Single-bit full adder: sums two operand bits x, y and a carry-in z, producing sum s and carry-out c.
- Arithmetic path is purely combinational. Used as the leaf cell for ripple adders and bit-serial datapaths.
- A clocked side path registers the results for pipelined consumers. It has one clock and an asynchronous active-low reset.

---
 rtl/full_adder_1b.sv | 55 +++++
 tb/tb_full_adder_1b.sv | 137 +++++++++++++
 2 files changed

// File: rtl/full_adder_1b.sv
// One-bit full adder with a combinational result and an optional registered
// copy. The registered copy can chain its own carry for bit-serial addition.
module full_adder_1b #(
  parameter bit OUT_REG = 1'b1,
  parameter bit SERIAL  = 1'b0
) (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic s_q,
  output logic c_q,
  output logic vld_q
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

  generate
    if (OUT_REG) begin : g_reg
      logic s_r;
      logic c_r;
      logic vld_r;
      logic cin_eff;

      // In serial mode the carry feeds back from the previous bit position.
      assign cin_eff = SERIAL ? c_r : z;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_r   <= 1'b0;
          c_r   <= 1'b0;
          vld_r <= 1'b0;
        end else if (en) begin
          s_r   <= x ^ y ^ cin_eff;
          c_r   <= (x & y) | (x & cin_eff) | (y & cin_eff);
          vld_r <= 1'b1;
        end
      end

      assign s_q   = s_r;
      assign c_q   = c_r;
      assign vld_q = vld_r;
    end else begin : g_noreg
      assign s_q   = 1'b0;
      assign c_q   = 1'b0;
      assign vld_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_1b.sv
// Directed bench for full_adder_1b: default, bit-serial and unregistered
// builds share one set of inputs; each scenario checks the relevant build.
module tb_full_adder_1b;

  logic clk = 1'b0;
  logic rst_n, x, y, z, en;
  logic d_s, d_c, d_sq, d_cq, d_vq;
  logic sr_s, sr_c, sr_sq, sr_cq, sr_vq;
  logic nr_s, nr_c, nr_sq, nr_cq, nr_vq;

  int checks = 0;
  int errors = 0;

  // Hand-computed {c,s} for {x,y,z} = 000 .. 111.
  logic [1:0] exp_tt [0:7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // 7 + 5 LSB first: operand bits and expected registered sum / carry per edge.
  logic [3:0] a_bits = 4'b0111;
  logic [3:0] b_bits = 4'b0101;
  logic [3:0] exp_sq = 4'b1100;
  logic [3:0] exp_cq = 4'b0111;

  always #5 clk = ~clk;

  full_adder_1b #(.OUT_REG(1'b1), .SERIAL(1'b0)) u_dflt (
    .s(d_s), .c(d_c), .x(x), .y(y), .z(z), .clk(clk), .rst_n(rst_n), .en(en),
    .s_q(d_sq), .c_q(d_cq), .vld_q(d_vq));

  full_adder_1b #(.OUT_REG(1'b1), .SERIAL(1'b1)) u_ser (
    .s(sr_s), .c(sr_c), .x(x), .y(y), .z(z), .clk(clk), .rst_n(rst_n), .en(en),
    .s_q(sr_sq), .c_q(sr_cq), .vld_q(sr_vq));

  full_adder_1b #(.OUT_REG(1'b0), .SERIAL(1'b0)) u_nreg (
    .s(nr_s), .c(nr_c), .x(x), .y(y), .z(z), .clk(clk), .rst_n(rst_n), .en(en),
    .s_q(nr_sq), .c_q(nr_cq), .vld_q(nr_vq));

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0;

    // Truth table, all builds, combinational only.
    for (int i = 0; i < 8; i++) begin
      {x, y, z} = i[2:0];
      #0;
      check_eq($sformatf("tt_same_step_%0d", i), {1'b0, d_c, d_s}, {1'b0, exp_tt[i]});
      #4;
      check_eq($sformatf("tt_dflt_%0d", i), {1'b0, d_c, d_s}, {1'b0, exp_tt[i]});
      check_eq($sformatf("tt_ser_%0d", i), {1'b0, sr_c, sr_s}, {1'b0, exp_tt[i]});
      check_eq($sformatf("tt_nreg_%0d", i), {1'b0, nr_c, nr_s}, {1'b0, exp_tt[i]});
    end

    // Reset holds registered outputs at zero while combinational path is live.
    x = 1'b1; y = 1'b1; z = 1'b1;
    #1;
    check_eq("rst_regs", {d_sq, d_cq, d_vq}, 3'b000);
    check_eq("rst_comb", {1'b0, d_c, d_s}, 3'b011);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    edge_sample();
    check_eq("rst_release_capture", {d_sq, d_cq, d_vq}, 3'b111);

    // Enable hold.
    @(negedge clk);
    x = 1'b1; y = 1'b0; z = 1'b0;
    edge_sample();
    check_eq("hold_capture", {d_sq, d_cq, d_vq}, 3'b101);
    @(negedge clk);
    en = 1'b0; x = 1'b1; y = 1'b1; z = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_sample();
      check_eq($sformatf("hold_regs_%0d", k), {d_sq, d_cq, d_vq}, 3'b101);
      check_eq($sformatf("hold_comb_%0d", k), {1'b0, d_c, d_s}, 3'b011);
    end

    // Bit-serial 7 + 5 with z held at 1 to show it is ignored.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("ser_rst", {sr_sq, sr_cq, sr_vq}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; z = 1'b1;
    for (int b = 0; b < 4; b++) begin
      x = a_bits[b]; y = b_bits[b];
      edge_sample();
      check_eq($sformatf("ser_bit_%0d", b), {sr_sq, sr_cq, sr_vq}, {exp_sq[b], exp_cq[b], 1'b1});
      @(negedge clk);
    end

    // Async reset mid-stream, then a fresh add must start with carry-in 0.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      x = a_bits[b]; y = b_bits[b];
      edge_sample();
      @(negedge clk);
    end
    check_eq("mid_before", {sr_sq, sr_cq, sr_vq}, 3'b011);
    x = 1'b1; y = 1'b0; z = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_clear", {sr_sq, sr_cq, sr_vq}, 3'b000);
    check_eq("mid_comb_live", {1'b0, sr_c, sr_s}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    check_eq("mid_restart_cin0", {sr_sq, sr_cq, sr_vq}, 3'b101);

    // Unregistered build: random activity, registered outputs stay 0.
    for (int r = 0; r < 40; r++) begin
      #($urandom_range(1, 7));
      {x, y, z} = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      #1;
      check_eq($sformatf("nreg_comb_%0d", r), {1'b0, nr_c, nr_s}, {1'b0, exp_tt[{x, y, z}]});
      check_eq($sformatf("nreg_regs_%0d", r), {nr_sq, nr_cq, nr_vq}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
